goertzel_det: RTL and testbench

GOERTZEL_DET -- requirements
Module: goertzel_det

---
 rtl/goertzel_det.sv | 137 +++++++++++++
 tb/tb_goertzel_det.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/goertzel_det.sv
// Single-bin Goertzel tone detector: per-sample IIR recurrence over blocks of N samples,
// then a two-stage pipeline forms the bin power and compares it against THR.
module goertzel_det #(
  parameter int  DW   = 10,
  parameter int  EW   = 9,
  parameter int  CF   = 14,
  parameter int  N    = 205,
  parameter real COEF = 0.0,
  parameter logic [2*(DW+EW)-1:0] THR = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     clr,
  input  logic signed [DW-1:0]     in,
  output logic [2*(DW+EW)-1:0]     power,
  output logic                     power_valid,
  output logic                     detect,
  output logic                     busy
);

  localparam int SW = DW + EW;
  localparam int PW = 2 * SW;
  localparam int QW = CF + 2;
  localparam int MW = SW + QW;
  localparam int TW = MW - CF;
  localparam int CP = PW + 2;
  localparam int CW = $clog2(N);
  localparam logic [CW-1:0] LAST = CW'(N - 1);
  localparam logic signed [QW-1:0] Q = QW'($rtoi(COEF * (2.0 ** CF)));

  logic signed [SW-1:0] s1_q, s2_q, snap1_q, snap2_q;
  logic [CW-1:0]        cnt_q;
  logic                 snap_vld_q, p1_vld_q, power_valid_q, detect_q;
  logic signed [PW-1:0] a_q, b_q;
  logic signed [CP-1:0] c_q;
  logic [PW-1:0]        power_q;

  // Recurrence datapath; the shifted product and the sum both wrap to SW bits.
  logic signed [MW-1:0] q_ext, s1_ext, qs_full;
  logic signed [SW-1:0] qs_t, in_ext, s0;

  assign q_ext   = {{SW{Q[QW-1]}}, Q};
  assign s1_ext  = {{QW{s1_q[SW-1]}}, s1_q};
  assign qs_full = q_ext * s1_ext;
  assign qs_t    = qs_full[SW+CF-1:CF];
  assign in_ext  = {{EW{in[DW-1]}}, in};
  assign s0      = in_ext + qs_t - s2_q;

  // Stage-1 products taken from the snapshot of the finished block.
  logic signed [MW-1:0] sn1_m, cs_full;
  logic signed [TW-1:0] cs_t;
  logic signed [PW-1:0] sn1_p, sn2_p, a_d, b_d;
  logic signed [CP-1:0] cs_c, sn2_c, c_d;

  assign sn1_m   = {{QW{snap1_q[SW-1]}}, snap1_q};
  assign cs_full = q_ext * sn1_m;
  assign cs_t    = cs_full[MW-1:CF];
  assign sn1_p   = {{SW{snap1_q[SW-1]}}, snap1_q};
  assign sn2_p   = {{SW{snap2_q[SW-1]}}, snap2_q};
  assign a_d     = sn1_p * sn1_p;
  assign b_d     = sn2_p * sn2_p;
  assign cs_c    = {{(CP-TW){cs_t[TW-1]}}, cs_t};
  assign sn2_c   = {{(CP-SW){snap2_q[SW-1]}}, snap2_q};
  assign c_d     = cs_c * sn2_c;

  // Stage 2: negative results clamp to 0, results beyond PW bits saturate.
  logic signed [CP:0] sum;
  logic [PW-1:0]      power_d;

  assign sum = {{3{a_q[PW-1]}}, a_q} + {{3{b_q[PW-1]}}, b_q} - {c_q[CP-1], c_q};

  always_comb begin
    power_d = sum[PW-1:0];
    if (sum[CP])
      power_d = '0;
    else if (|sum[CP-1:PW])
      power_d = '1;
  end

  logic unused_bits;
  assign unused_bits = ^{qs_full[MW-1:SW+CF], qs_full[CF-1:0], cs_full[CF-1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q          <= '0;
      s2_q          <= '0;
      snap1_q       <= '0;
      snap2_q       <= '0;
      cnt_q         <= '0;
      snap_vld_q    <= 1'b0;
      p1_vld_q      <= 1'b0;
      a_q           <= '0;
      b_q           <= '0;
      c_q           <= '0;
      power_q       <= '0;
      power_valid_q <= 1'b0;
      detect_q      <= 1'b0;
    end else begin
      snap_vld_q <= 1'b0;
      if (clr) begin
        s1_q  <= '0;
        s2_q  <= '0;
        cnt_q <= '0;
      end else if (en) begin
        if (cnt_q == LAST) begin
          // Last sample: snapshot and restart in one edge so the next sample is sample 0.
          snap1_q    <= s0;
          snap2_q    <= s1_q;
          snap_vld_q <= 1'b1;
          s1_q       <= '0;
          s2_q       <= '0;
          cnt_q      <= '0;
        end else begin
          s1_q  <= s0;
          s2_q  <= s1_q;
          cnt_q <= cnt_q + 1'b1;
        end
      end
      p1_vld_q      <= snap_vld_q;
      a_q           <= a_d;
      b_q           <= b_d;
      c_q           <= c_d;
      power_valid_q <= p1_vld_q;
      if (p1_vld_q) begin
        power_q  <= power_d;
        detect_q <= (power_d >= THR);
      end
    end
  end

  assign power       = power_q;
  assign power_valid = power_valid_q;
  assign detect      = detect_q;
  assign busy        = (cnt_q != '0);

endmodule

// File: tb/tb_goertzel_det.sv
// Bench for goertzel_det with N=8, COEF=0: table of blocks, corner-case sequences
// for clr/reset/gaps, and a queue of expected power results with arrival cycles.
module tb_goertzel_det;

  localparam int DW = 10;
  localparam int EW = 9;
  localparam int CF = 14;
  localparam int N  = 8;
  localparam int SW = DW + EW;
  localparam int PW = 2 * SW;
  localparam logic [PW-1:0] THR = 38'd500000;

  typedef struct packed {
    logic [7:0][DW-1:0] s;
    logic [PW-1:0]      p;
    logic               d;
  } vec_t;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b1;
  logic                 en = 1'b0;
  logic                 clr = 1'b0;
  logic signed [DW-1:0] in_s = '0;
  logic [PW-1:0]        power;
  logic                 power_valid, detect, busy;

  goertzel_det #(
    .DW(DW), .EW(EW), .CF(CF), .N(N), .COEF(0.0), .THR(THR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .clr(clr), .in(in_s),
    .power(power), .power_valid(power_valid), .detect(detect), .busy(busy)
  );

  // Clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard
  int checks = 0;
  int errors = 0;
  int pulses = 0;
  logic [PW:0]   exp_q[$];
  int            t_q[$];
  logic [PW-1:0] last_p = '0;
  logic          last_d = 1'b0;
  bit            mon_on = 1'b0;
  logic [PW:0]   mon_e;
  int            mon_t;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      if (!rst_n) begin
        check("rst_power", power, 0);
        check("rst_power_valid", power_valid, 0);
        check("rst_detect", detect, 0);
        check("rst_busy", busy, 0);
        last_p = '0;
        last_d = 1'b0;
      end else if (power_valid) begin
        pulses++;
        check("pulse_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          mon_e = exp_q.pop_front();
          mon_t = t_q.pop_front();
          check("pulse_cycle", cyc, mon_t);
          check("power", power, mon_e[PW-1:0]);
          check("detect", detect, mon_e[PW]);
          last_p = mon_e[PW-1:0];
          last_d = mon_e[PW];
        end
      end else begin
        check("power_hold", power, last_p);
        check("detect_hold", detect, last_d);
      end
    end
  end

  // Driver tasks
  task automatic drive(input logic e, input logic c, input logic [DW-1:0] x);
    @(negedge clk);
    en   = e;
    clr  = c;
    in_s = x;
  endtask

  // Called right after the last sample is driven: accepted next edge, pulse 2 edges later.
  task automatic expect_pulse(input logic [PW-1:0] p, input logic d);
    exp_q.push_back({d, p});
    t_q.push_back(cyc + 3);
  endtask

  task automatic send_block(input logic [7:0][DW-1:0] s, input logic [PW-1:0] p,
                            input logic d, input bit gap, input bit push);
    for (int i = 0; i < N; i++) begin
      if (gap && i > 0) begin
        drive(1'b0, 1'b0, '0);
        check("busy_gap", busy, 1);
      end
      drive(1'b1, 1'b0, s[i]);
      if (i == N - 1 && push) expect_pulse(p, d);
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) drive(1'b0, 1'b0, '0);
    check("drain_empty", exp_q.size() == 0, 1);
    exp_q.delete();
    t_q.delete();
    repeat (4) drive(1'b0, 1'b0, '0);
  endtask

  function automatic logic [7:0][DW-1:0] tone(input int a);
    logic [7:0][DW-1:0] r;
    for (int i = 0; i < 8; i++)
      r[i] = (i % 4 == 0) ? DW'(a) : (i % 4 == 2) ? DW'(-a) : '0;
    return r;
  endfunction

  function automatic logic [7:0][DW-1:0] fill(input int v0, input int rest);
    logic [7:0][DW-1:0] r;
    for (int i = 0; i < 8; i++) r[i] = (i == 0) ? DW'(v0) : DW'(rest);
    return r;
  endfunction

  // Reference for COEF=0: s0 = x - s2, power = s1^2 + s2^2.
  function automatic logic [PW-1:0] model(input logic [7:0][DW-1:0] s);
    longint s1, s2, s0, x;
    s1 = 0;
    s2 = 0;
    for (int i = 0; i < 8; i++) begin
      x  = longint'($signed(s[i]));
      s0 = x - s2;
      s2 = s1;
      s1 = s0;
    end
    return PW'(s1 * s1 + s2 * s2);
  endfunction

  vec_t vt[7];
  int   p0;
  logic [7:0][DW-1:0] rs;
  logic [PW-1:0]      rp;

  initial begin
    vt[0] = '{s: tone(256),  p: 38'd1048576, d: 1'b1};
    vt[1] = '{s: fill(256, 256), p: 38'd0,   d: 1'b0};
    vt[2] = '{s: fill(100, 0), p: 38'd10000, d: 1'b0};
    vt[3] = '{s: fill(0, 0),   p: 38'd0,     d: 1'b0};
    vt[4] = '{s: tone(177),  p: 38'd501264,  d: 1'b1};
    vt[5] = '{s: tone(176),  p: 38'd495616,  d: 1'b0};
    vt[6] = '{s: tone(511),  p: 38'd4177936, d: 1'b1};

    // Reset
    #1 rst_n = 1'b0;
    mon_on = 1'b1;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;

    // Table of single blocks
    for (int i = 0; i < 7; i++) begin
      send_block(vt[i].s, vt[i].p, vt[i].d, 1'b0, 1'b1);
      drive(1'b0, 1'b0, '0);
      check("busy_after_block", busy, 0);
      drain();
    end

    // Continuous: three back-to-back tone blocks, pulses 8 cycles apart
    p0 = pulses;
    for (int b = 0; b < 3; b++) send_block(tone(256), 38'd1048576, 1'b1, 1'b0, 1'b1);
    drain();
    check("cont_pulses", pulses - p0, 3);

    // Gapped: en toggles, accumulator frozen on idle cycles
    send_block(tone(256), 38'd1048576, 1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b0, '0);
    check("busy_after_gapped", busy, 0);
    drain();

    // clr after 5 samples (with a discarded sample), then a fresh block
    p0 = pulses;
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, tone(256)[i]);
    drive(1'b1, 1'b1, 10'd256);
    drive(1'b0, 1'b0, '0);
    check("busy_after_clr", busy, 0);
    send_block(tone(256), 38'd1048576, 1'b1, 1'b0, 1'b1);
    drain();
    check("clr_restart_pulses", pulses - p0, 1);

    // clr coinciding with the 8th sample: no snapshot, no pulse
    p0 = pulses;
    for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, tone(300)[i]);
    drive(1'b1, 1'b1, '0);
    drive(1'b0, 1'b0, '0);
    check("busy_after_clr8", busy, 0);
    drain();
    check("clr8_pulses", pulses - p0, 0);

    // clr right after the 8th sample does not cancel the pending result
    p0 = pulses;
    send_block(tone(177), 38'd501264, 1'b1, 1'b0, 1'b1);
    drive(1'b0, 1'b1, '0);
    drain();
    check("clr_after_snap_pulses", pulses - p0, 1);

    // Reset between the 8th edge and power_valid: result discarded
    p0 = pulses;
    send_block(tone(256), 38'd0, 1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, '0);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    drain();
    check("rst_pipe_pulses", pulses - p0, 0);

    // Reset mid-block: next block starts at sample 0
    for (int i = 0; i < 3; i++) drive(1'b1, 1'b0, 10'd200);
    drive(1'b0, 1'b0, '0);
    #2 rst_n = 1'b0;
    @(negedge clk);
    #2 rst_n = 1'b1;
    send_block(tone(256), 38'd1048576, 1'b1, 1'b0, 1'b1);
    drain();

    // Random blocks back-to-back against the reference
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < 8; i++) rs[i] = DW'($urandom_range(0, 1023));
      rp = model(rs);
      send_block(rs, rp, rp >= THR, 1'b0, 1'b1);
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
